// File: rtl/dpram_sched_pkg.sv
// Shared definitions for the dual-port RAM read scheduler.
package dpram_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Tag travelling alongside each read beat: {valid, id, last}.
    localparam int TAG_W     = 3;
    localparam int TAG_VALID = 2;
    localparam int TAG_ID    = 1;
    localparam int TAG_LAST  = 0;

endpackage

// File: rtl/dpram_tag_pipe.sv
// Fixed-latency shift register that carries beat tags alongside the RAM read data.
module dpram_tag_pipe
    import dpram_sched_pkg::*;
#(
    parameter int N_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out,
    output logic             any_valid
);

    logic [TAG_W-1:0] pipe [N_DELAY];

    // Shift one tag per cycle; reset drops every beat in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DELAY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < N_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Any valid beat still travelling keeps the scheduler busy.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < N_DELAY; i++) begin
            any_valid = any_valid | pipe[i][TAG_VALID];
        end
    end

    assign tag_out = pipe[N_DELAY-1];

endmodule

// File: rtl/dpram_rd_sched.sv
// Round-robin burst read scheduler for one dual-port RAM read port.
// Two clients post bursts; the winner's addresses are issued one per cycle
// and the returning words are tagged with client id and last-beat flag.
module dpram_rd_sched
    import dpram_sched_pkg::*;
#(
    parameter int DW      = 64,
    parameter int AW      = 8,
    parameter int DEPTH   = 256,
    parameter int N_DELAY = 1,
    parameter int LW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] base0,
    input  logic [LW-1:0] len0,
    input  logic          req1,
    input  logic [AW-1:0] base1,
    input  logic [LW-1:0] len1,
    output logic          ack0,
    output logic          ack1,
    output logic          done0,
    output logic          done1,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] dob,
    output logic          rvalid,
    output logic          rid,
    output logic          rlast,
    output logic [DW-1:0] rdata,
    output logic          busy
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] cnt;
    logic [AW-1:0] addr;
    logic          cur_id;
    logic          rr;
    logic          ack0_q;
    logic          ack1_q;
    logic          grant;
    logic          winner;
    logic          last_beat;
    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_out;
    logic          pipe_busy;

    assign last_beat = (cnt == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration in IDLE, burst termination in ISSUE.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        winner    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant     = 1'b1;
                    winner    = (req0 & req1) ? rr : req1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst bookkeeping: load on grant, then walk address and count down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            addr   <= '0;
            cur_id <= 1'b0;
            rr     <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
        end else begin
            ack0_q <= grant & ~winner;
            ack1_q <= grant & winner;
            if (grant) begin
                addr   <= winner ? base1 : base0;
                cnt    <= winner ? len1 : len0;
                cur_id <= winner;
                rr     <= ~winner;
            end else if (state == ISSUE) begin
                // Wrap at the RAM depth, which may be smaller than 2**AW.
                addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
                if (!last_beat) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign enb   = (state == ISSUE);
    assign addrb = addr;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;

    // Id and last are gated by enb so idle slots carry an all-zero tag.
    assign tag_in = {enb, enb & cur_id, enb & last_beat};

    dpram_tag_pipe #(
        .N_DELAY (N_DELAY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (pipe_busy)
    );

    assign rvalid = tag_out[TAG_VALID];
    assign rid    = tag_out[TAG_ID];
    assign rlast  = tag_out[TAG_LAST];
    assign rdata  = dob;
    assign done0  = rvalid & rlast & ~rid;
    assign done1  = rvalid & rlast & rid;
    assign busy   = enb | pipe_busy;

endmodule

// File: tb/tb_dpram_rd_sched.sv
// Scoreboard bench: instance 0 (DEPTH=208, N_DELAY=1), instance 1 (DEPTH=256, N_DELAY=3).
module tb_dpram_rd_sched;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int LW = 8;

    typedef struct {
        int             cyc;
        logic           id;
        logic           last;
        logic [DW-1:0]  data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst, req0, req1, ack0, ack1, done0, done1, enb, rvalid, rid, rlast, busy;
    logic [AW-1:0] base0 [2];
    logic [AW-1:0] base1 [2];
    logic [AW-1:0] addrb [2];
    logic [LW-1:0] len0 [2];
    logic [LW-1:0] len1 [2];
    logic [DW-1:0] dob [2];
    logic [DW-1:0] rdata [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sbq0 [$];
    exp_t sbq1 [$];
    exp_t mon_e;

    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int ND = (g == 0) ? 1 : 3;
        localparam int DP = (g == 0) ? 208 : 256;
        logic [DW-1:0] dpipe [ND];

        dpram_rd_sched #(.DW(DW), .AW(AW), .DEPTH(DP), .N_DELAY(ND), .LW(LW)) u_dut (
            .clk(clk), .rst(rst[g]),
            .req0(req0[g]), .base0(base0[g]), .len0(len0[g]),
            .req1(req1[g]), .base1(base1[g]), .len1(len1[g]),
            .ack0(ack0[g]), .ack1(ack1[g]), .done0(done0[g]), .done1(done1[g]),
            .enb(enb[g]), .addrb(addrb[g]), .dob(dob[g]),
            .rvalid(rvalid[g]), .rid(rid[g]), .rlast(rlast[g]), .rdata(rdata[g]),
            .busy(busy[g])
        );

        // RAM model with mem[i] = i and ND cycles of read latency.
        always @(posedge clk) begin
            if (enb[g]) dpipe[0] <= DW'(addrb[g]);
            for (int i = 1; i < ND; i++) dpipe[i] <= dpipe[i-1];
        end
        assign dob[g] = dpipe[ND-1];
    end

    function automatic int nd_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int depth_of(input int g);
        return (g == 0) ? 208 : 256;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_burst(input int g, input int id, input int ack_cyc);
        int base, len;
        exp_t e;
        base = (id != 0) ? int'(base1[g]) : int'(base0[g]);
        len  = (id != 0) ? int'(len1[g])  : int'(len0[g]);
        for (int k = 0; k <= len; k++) begin
            e.cyc  = ack_cyc + k + nd_of(g);
            e.id   = (id != 0);
            e.last = (k == len);
            e.data = DW'((base + k) % depth_of(g));
            if (g == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
        end
    endtask

    task automatic wait_ack(input int g, input int exp_id, input int exp_cyc, input string name);
        bit seen = 1'b0;
        int id;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ack0[g] | ack1[g]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ack within 40 cycles, expected client %0d", name, exp_id);
            return;
        end
        id = int'(ack1[g]);
        chk({name, "_id"}, id, exp_id);
        chk({name, "_cycle"}, cyc, exp_cyc);
        chk({name, "_enb_addr"}, {enb[g], addrb[g]},
            {1'b1, (exp_id != 0) ? base1[g] : base0[g]});
        push_burst(g, id, cyc);
    endtask

    task automatic drain(input int g);
        repeat (6) @(negedge clk);
        chk("drain_idle", {busy[g], enb[g]}, 0);
    endtask

    // Monitor: every valid beat must match the head of that instance's queue.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst[g]) begin
                if (rvalid[g]) begin
                    checks++;
                    if ((g == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected inst%0d: got rid=%0b data=%0h expected no beat (cycle %0d)",
                                 g, rid[g], rdata[g], cyc);
                    end else begin
                        mon_e = (g == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        if (rid[g] !== mon_e.id || rlast[g] !== mon_e.last || rdata[g] !== mon_e.data ||
                            cyc != mon_e.cyc ||
                            {done1[g], done0[g]} !== (mon_e.last ? (mon_e.id ? 2'b10 : 2'b01) : 2'b00)) begin
                            errors++;
                            $display("FAIL beat inst%0d: got cyc=%0d rid=%0b rlast=%0b done=%b data=%0h expected cyc=%0d rid=%0b rlast=%0b data=%0h",
                                     g, cyc, rid[g], rlast[g], {done1[g], done0[g]}, rdata[g],
                                     mon_e.cyc, mon_e.id, mon_e.last, mon_e.data);
                        end
                    end
                end else begin
                    checks++;
                    if (done0[g] | done1[g]) begin
                        errors++;
                        $display("FAIL done_without_valid inst%0d: got done=%b expected 00", g, {done1[g], done0[g]});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, dn;
        logic [AW-1:0] wrap_exp [3];
        rst = 2'b11; req0 = '0; req1 = '0;
        for (int g = 0; g < 2; g++) begin
            base0[g] = '0; base1[g] = '0; len0[g] = '0; len1[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("reset_outputs", {ack0[g], ack1[g], done0[g], done1[g], enb[g], rvalid[g],
                                  rid[g], rlast[g], busy[g], addrb[g]}, 0);
        end
        @(posedge clk); #1; rst = 2'b00;

        // Single burst: client 0, base 10, len 3.
        @(posedge clk); #1;
        base0[0] = 8'd10; len0[0] = 8'd3; req0[0] = 1'b1; t = cyc;
        wait_ack(0, 0, t + 1, "single_ack");
        req0[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("single_addrb", {enb[0], addrb[0]}, {1'b1, 8'(10 + k)});
        end
        @(negedge clk);
        chk("single_enb_off", enb[0], 0);
        drain(0);

        // Address wrap at DEPTH=208.
        @(posedge clk); #1;
        base1[0] = 8'd206; len1[0] = 8'd3; req1[0] = 1'b1; t = cyc;
        wait_ack(0, 1, t + 1, "wrap_ack");
        req1[0] = 1'b0;
        wrap_exp[0] = 8'd207; wrap_exp[1] = 8'd0; wrap_exp[2] = 8'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wrap_addrb", {enb[0], addrb[0]}, {1'b1, wrap_exp[k]});
        end
        drain(0);

        // Fresh reset so the round-robin pointer prefers client 0.
        @(posedge clk); #1; rst[0] = 1'b1;
        @(posedge clk); #1; rst[0] = 1'b0;

        // Contention and fairness.
        @(posedge clk); #1;
        base0[0] = 8'd40; len0[0] = 8'd1; base1[0] = 8'd60; len1[0] = 8'd1;
        req0[0] = 1'b1; req1[0] = 1'b1; t = cyc;
        wait_ack(0, 0, t + 1, "pair1_first");
        req0[0] = 1'b0;
        wait_ack(0, 1, t + 4, "pair1_second");
        req1[0] = 1'b0;
        drain(0);

        @(posedge clk); #1;
        base0[0] = 8'd70; len0[0] = 8'd0; req0[0] = 1'b1; t = cyc;
        wait_ack(0, 0, t + 1, "solo_ack");
        req0[0] = 1'b0;
        drain(0);

        @(posedge clk); #1;
        base0[0] = 8'd80; len0[0] = 8'd1; base1[0] = 8'd90; len1[0] = 8'd1;
        req0[0] = 1'b1; req1[0] = 1'b1; t = cyc;
        wait_ack(0, 1, t + 1, "pair2_first");
        req1[0] = 1'b0;
        wait_ack(0, 0, t + 4, "pair2_second");
        req0[0] = 1'b0;
        drain(0);

        // Reset during beat 2 of an 8-beat burst.
        @(posedge clk); #1;
        base0[0] = 8'd100; len0[0] = 8'd7; req0[0] = 1'b1; t = cyc;
        wait_ack(0, 0, t + 1, "rstmid_ack");
        req0[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst[0] = 1'b1;
        sbq0.delete();
        #1;
        chk("rstmid_outputs", {ack0[0], ack1[0], done0[0], done1[0], enb[0], rvalid[0],
                               rid[0], rlast[0], busy[0], addrb[0]}, 0);
        @(posedge clk); #1; rst[0] = 1'b0;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            dn += int'(done0[0]) + int'(done1[0]);
        end
        chk("rstmid_no_done", dn, 0);
        chk("rstmid_idle", {busy[0], enb[0]}, 0);

        @(posedge clk); #1;
        base0[0] = 8'd110; len0[0] = 8'd0; base1[0] = 8'd120; len1[0] = 8'd0;
        req0[0] = 1'b1; req1[0] = 1'b1; t = cyc;
        wait_ack(0, 0, t + 1, "postrst_first");
        req0[0] = 1'b0;
        wait_ack(0, 1, t + 3, "postrst_second");
        req1[0] = 1'b0;
        drain(0);

        // Latency tagging at N_DELAY=3: alternating len=0 bursts.
        @(posedge clk); #1;
        base0[1] = 8'd20; len0[1] = 8'd0; base1[1] = 8'd30; len1[1] = 8'd0;
        req0[1] = 1'b1; req1[1] = 1'b1; t = cyc;
        for (int j = 0; j < 4; j++) begin
            wait_ack(1, j % 2, t + 1 + 2 * j, "lat_ack");
            if (j == 3) begin
                req0[1] = 1'b0;
                req1[1] = 1'b0;
            end
            @(negedge clk);
            chk("lat_bubble", enb[1], 0);
        end
        drain(1);

        chk("scoreboard_empty", sbq0.size() + sbq1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
